// File: rtl/program_loader.sv
// Boot loader: accepts a framed byte stream (length, hi/lo word pairs, XOR checksum),
// writes the words to instruction memory from address 0 and releases the core on success.
module program_loader #(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  CLK_pi,
  input  logic                  RESET_pi,
  input  logic                  start_pi,
  input  logic                  byte_valid_pi,
  input  logic [7:0]            byte_data_pi,
  output logic                  byte_ready_po,
  output logic                  imem_we_po,
  output logic [ADDR_WIDTH-1:0] imem_addr_po,
  output logic [15:0]           imem_data_po,
  output logic                  cpu_reset_po,
  output logic                  load_done_po,
  output logic                  load_error_po,
  output logic [2:0]            dbg_state_po
);

  // Handshake: a byte transfers on a rising edge where byte_valid_pi and byte_ready_po are both 1;
  // byte_ready_po depends only on the current state, never on byte_valid_pi.
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  state_t                r_state;
  state_t                w_next_state;
  logic [7:0]            r_len_hi;
  logic [15:0]           r_len;
  logic [7:0]            r_hi;
  logic [16:0]           r_word_cnt;
  logic [7:0]            r_chk;
  logic [TW-1:0]         r_timer;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_data;
  logic                  r_cpu_reset;
  logic                  r_done;
  logic                  r_error;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_start;
  logic [15:0]           w_len;
  logic                  w_len_bad;
  logic [16:0]           w_word_next;
  logic                  w_expired;

  assign w_ready     = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) || (r_state == S_DATA_HI) ||
                       (r_state == S_DATA_LO) || (r_state == S_CHECK);
  assign w_accept    = w_ready && byte_valid_pi;
  assign w_start     = start_pi && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
  assign w_len       = {r_len_hi, byte_data_pi};
  assign w_len_bad   = (w_len == 16'd0) || ({1'b0, w_len} > MAX_WORDS);
  assign w_word_next = r_word_cnt + 17'd1;
  // An accepted byte on the expiring cycle takes priority over the timeout.
  assign w_expired   = w_ready && !w_accept && (r_timer == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (w_start) w_next_state = S_LEN_HI;
      S_LEN_HI:  if (w_accept) w_next_state = S_LEN_LO;
      S_LEN_LO:  if (w_accept) w_next_state = w_len_bad ? S_ERROR : S_DATA_HI;
      S_DATA_HI: if (w_accept) w_next_state = S_DATA_LO;
      S_DATA_LO: if (w_accept) w_next_state = (w_word_next == {1'b0, r_len}) ? S_CHECK : S_DATA_HI;
      S_CHECK:   if (w_accept) w_next_state = (byte_data_pi == r_chk) ? S_DONE : S_ERROR;
      default:   w_next_state = S_IDLE;
    endcase
    if (w_expired) w_next_state = S_ERROR;
  end

  always_ff @(posedge CLK_pi or negedge RESET_pi) begin
    if (!RESET_pi) begin
      r_state     <= S_IDLE;
      r_len_hi    <= '0;
      r_len       <= '0;
      r_hi        <= '0;
      r_word_cnt  <= '0;
      r_chk       <= '0;
      r_timer     <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_we    <= 1'b0;
      if (w_start) begin
        r_chk       <= '0;
        r_word_cnt  <= '0;
        r_timer     <= '0;
        r_cpu_reset <= 1'b1;
        r_done      <= 1'b0;
        r_error     <= 1'b0;
      end else if (w_accept) begin
        r_timer <= '0;
        if (r_state != S_CHECK) r_chk <= r_chk ^ byte_data_pi;
        case (r_state)
          S_LEN_HI:  r_len_hi <= byte_data_pi;
          S_LEN_LO:  r_len    <= w_len;
          S_DATA_HI: r_hi     <= byte_data_pi;
          S_DATA_LO: begin
            r_we       <= 1'b1;
            r_addr     <= r_word_cnt[ADDR_WIDTH-1:0];
            r_data     <= {r_hi, byte_data_pi};
            r_word_cnt <= w_word_next;
          end
          default: ;
        endcase
      end else if (w_ready) begin
        r_timer <= w_expired ? '0 : r_timer + TW'(1);
      end
      if (w_next_state == S_DONE && r_state != S_DONE) begin
        r_done      <= 1'b1;
        r_cpu_reset <= 1'b0;
      end
      if (w_next_state == S_ERROR && r_state != S_ERROR) r_error <= 1'b1;
    end
  end

  assign byte_ready_po = w_ready;
  assign imem_we_po    = r_we;
  assign imem_addr_po  = r_addr;
  assign imem_data_po  = r_data;
  assign cpu_reset_po  = r_cpu_reset;
  assign load_done_po  = r_done;
  assign load_error_po = r_error;
  assign dbg_state_po  = r_state;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Upstream boot stage for the 16-bit single-cycle processor. It receives a framed byte stream over a valid/ready interface and assembles 16-bit instruction words. It writes those words sequentially into instruction memory from address 0. The processor core is held in reset until a frame is accepted with a valid length and checksum.

Parameters:
ADDR_WIDTH, 8, instruction memory address width; depth is 2**ADDR_WIDTH words.
TIMEOUT_CYCLES, 1000, maximum number of idle cycles allowed between accepted bytes inside a frame.

Ports:
CLK_pi  input  1  system clock; all state updates on the rising edge.
RESET_pi  input  1  asynchronous, active-low reset.
start_pi  input  1  single-cycle request to begin a load; honoured only in IDLE, DONE and ERROR.
byte_valid_pi  input  1  byte_data_pi carries a valid byte.
byte_data_pi  input  8  incoming stream byte.
byte_ready_po  output  1  loader can accept a byte; a byte transfers when valid and ready are both 1 on a clock edge.
imem_we_po  output  1  instruction memory write strobe, one cycle wide.
imem_addr_po  output  ADDR_WIDTH  instruction memory write address.
imem_data_po  output  16  instruction word to write.
cpu_reset_po  output  1  active-high reset to the core; 1 means the core is held in reset.
load_done_po  output  1  a load completed successfully; held until the next start.
load_error_po  output  1  the last load failed; held until the next start.

Behaviour:
- Frame format: LEN_HI, LEN_LO, then N words sent as a high byte followed by a low byte, then CHK.
  - N = {LEN_HI, LEN_LO}.
  - CHK is the 8-bit XOR of every preceding byte in the frame, length bytes included.
- Reset values (RESET_pi=0, asynchronous):
  - state = IDLE.
  - byte_ready_po=0, imem_we_po=0, imem_addr_po=0, imem_data_po=0.
  - cpu_reset_po=1, load_done_po=0, load_error_po=0.
  - Word counter, checksum accumulator and timeout counter all cleared.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR.
- byte_ready_po is 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK. It is 0 in IDLE, DONE and ERROR.
- start_pi handling:
  - In IDLE, DONE or ERROR, start_pi moves to LEN_HI on the next edge.
  - On that same edge: cpu_reset_po=1, load_done_po=0, load_error_po=0, checksum and word counter cleared.
  - start_pi is ignored in every other state.
- Transition rules, per accepted byte:
  - LEN_HI -> LEN_LO.
  - LEN_LO: if N==0 or N>2**ADDR_WIDTH, go to ERROR (the length byte itself is accepted). Otherwise go to DATA_HI.
  - DATA_HI: latch the high byte, go to DATA_LO.
  - DATA_LO: go to DATA_HI, or to CHECK if this was word N.
  - CHECK: if the byte equals the accumulated XOR, go to DONE; otherwise go to ERROR.
- Memory write:
  - Issued on the edge after the DATA_LO byte is accepted.
  - imem_we_po=1 for exactly one cycle, imem_addr_po = word index (0..N-1), imem_data_po = {hi,lo}.
  - At most one write per two bytes, so back-to-back bytes never stall.
  - imem_addr_po and imem_data_po hold their last values when imem_we_po=0.
- Checksum: XOR accumulator updated on every accepted byte except CHK.
- Entering DONE: load_done_po=1 and cpu_reset_po=0 on the transition edge. The core starts fetching at PC 0 on the following cycle.
- Entering ERROR: load_error_po=1; cpu_reset_po stays 1.
  - Words already written stay in memory; they are not rolled back.
- Timeout:
  - The counter runs only in LEN_HI through CHECK and clears on every accepted byte.
  - On reaching TIMEOUT_CYCLES with no accepted byte, go to ERROR.
  - A byte accepted on the same cycle the count would expire wins; no error is raised.
- Reset asserted mid-frame aborts the load immediately and returns every output to its reset value. Partial memory contents are left as written.
- byte_data_pi is ignored when byte_valid_pi=0 or byte_ready_po=0.

Test Plan:
- Basic load: pulse start, send 00 02 12 34 AB CD 42. Expect writes addr0=0x1234 and addr1=0xABCD, one cycle each; load_done_po=1, cpu_reset_po=0 and load_error_po=0 after the 42 is accepted.
- Bad checksum: same frame with CHK=0x43. Expect both words written, then load_error_po=1, cpu_reset_po=1, load_done_po=0.
- Bad length: send 00 00, and with ADDR_WIDTH=8 send 01 01. Expect ERROR right after LEN_LO, no imem_we_po pulse, byte_ready_po=0.
- Timeout: send 00 01 12, then hold byte_valid_pi=0 for TIMEOUT_CYCLES cycles. Expect load_error_po=1 and no write; a byte delivered exactly at expiry completes normally instead.
- Reset mid-load: drive RESET_pi=0 after byte AB of the basic frame. Expect all outputs at reset values immediately; a new start followed by the full basic frame then succeeds.
- Reload: after a successful load, pulse start. Expect cpu_reset_po=1 and load_done_po=0 on the next edge; start_pi pulses during DATA states have no effect.
